// File: rtl/prio_enc_pkg.sv
// Shared constants for the round-robin priority encoder: mode encodings,
// default request width and grant counter width.
package prio_enc_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   N_DEFAULT  = 8;
    localparam int   CNT_W      = 16;
endpackage

// File: rtl/prio_enc_core.sv
// Combinational wrap-around search: scans d downward from start, first set bit
// wins; none is raised (with idx = 0) when d is all-zero.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] d,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         none
);
    // Walk from the farthest position toward start so the nearest hit is written last.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            int p;
            p = int'(start) - k;
            if (p < 0) p = p + N;
            if (d[p]) begin
                idx  = W'(p);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/prio_encoder_rr.sv
// Priority encoder with fixed / round-robin modes and a one-deep ready/valid
// output register. Define PRIO_ENC_COUNT_EN to build the saturating grant counter.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    output logic [W-1:0]     y,
    output logic             none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt
);
    logic [W-1:0] last;
    logic [W-1:0] start;
    logic [W-1:0] win;
    logic         win_none;
    logic         accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // last == 0 wraps to N-1, which also makes the first search after reset match fixed mode.
    assign start = (mode == MODE_RR && last != '0) ? last - W'(1) : W'(N - 1);

    prio_enc_core #(.N(N), .W(W)) u_core (
        .d     (d),
        .start (start),
        .idx   (win),
        .none  (win_none)
    );

    // Output register stage: result lands one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            none      <= 1'b0;
            last      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= win;
            none      <= win_none;
            if (!win_none) last <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_valid && out_ready && !none) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign grant_cnt = cnt;
`else
    assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr (N=8): directed scenarios plus random
// traffic, checked against a search-based reference model.
module tb_prio_encoder_rr;
    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        int y;
        bit none;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  d = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [W-1:0]  y;
    logic          none;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   grant_cnt;

    int n_checks = 0;
    int n_pass = 0;

    res_t q[$];
    bit   ov_m = 0;
    bit   cur_none_m = 0;
    int   last_m = 0;
    int   cnt_m = 0;

    prio_encoder_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .y         (y),
        .none      (none),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Winner = first requester met scanning downward (with wrap) from the start point.
    function automatic int pick(input logic [N-1:0] dv, input bit rr, input int lst);
        int s;
        s = rr ? (lst + N - 1) % N : N - 1;
        for (int k = 0; k < N; k++)
            if (dv[(s - k + N) % N]) return (s - k + N) % N;
        return -1;
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef PRIO_ENC_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Reference model: tracks what the block should hold after each edge.
    always @(posedge clk) begin
        bit acc;
        bit hs;
        int w;
        res_t r;
        if (rst) begin
            ov_m = 0;
            cur_none_m = 0;
            last_m = 0;
            cnt_m = 0;
            q.delete();
        end else begin
            acc = in_valid && (!ov_m || out_ready);
            hs  = ov_m && out_ready;
            if (hs && !cur_none_m && cnt_m < 16'hFFFF) cnt_m++;
            if (acc) begin
                w = pick(d, mode, last_m);
                r.none = (w < 0);
                r.y = r.none ? 0 : w;
                if (!r.none) last_m = w;
                q.push_back(r);
                ov_m = 1;
                cur_none_m = r.none;
            end else if (hs) begin
                ov_m = 0;
            end
        end
    end

    // Monitor: compares presented outputs against the scoreboard, pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, (q.size() == 0) || out_ready);
            chk("grant_cnt", grant_cnt, exp_cnt(cnt_m));
            if (out_valid && q.size() != 0) begin
                chk("y", y, q[0].y);
                chk("none", none, q[0].none);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input bit v, input logic [N-1:0] dv, input bit md, input bit ordy);
        in_valid  = v;
        d         = dv;
        mode      = md;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_none", none, 0);
        chk("rst_grant_cnt", grant_cnt, 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rd;
        do_reset();

        // Fixed mode basics, then an all-zero request.
        step(1, 8'b1010_0000, 0, 1);
        chk("fixed_a0_y", y, 7);
        chk("fixed_a0_none", none, 0);
        step(1, 8'h00, 0, 1);
        chk("zero_y", y, 0);
        chk("zero_none", none, 1);
        step(1, 8'h01, 1, 1);
        chk("rr_after_zero_y", y, 0);
        step(0, '0, 0, 1);

        // Round-robin rotation and wrap.
        do_reset();
        step(1, 8'hFF, 1, 1); chk("rr_ff_1", y, 7);
        step(1, 8'hFF, 1, 1); chk("rr_ff_2", y, 6);
        step(1, 8'hFF, 1, 1); chk("rr_ff_3", y, 5);
        step(1, 8'hFF, 1, 1); chk("rr_ff_4", y, 4);
        step(1, 8'h81, 1, 1); chk("rr_81_1", y, 0);
        step(1, 8'h81, 1, 1); chk("rr_81_2", y, 7);

        // Back-pressure hold with y=3 presented.
        step(1, 8'hFF, 1, 1); chk("rr_ff_5", y, 6);
        step(1, 8'hFF, 1, 1);
        step(1, 8'hFF, 1, 1);
        step(1, 8'hFF, 1, 1); chk("hold_setup_y", y, 3);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h10, 1, 0);
            chk("hold_y", y, 3);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        step(1, 8'h10, 1, 1);
        chk("after_hold_y", y, 4);
        step(0, '0, 1, 1);

        // Reset discards an in-flight result.
        step(1, 8'h3C, 1, 0);
        chk("inflight_valid", out_valid, 1);
        rst = 1'b1;
        step(0, '0, 1, 0);
        rst = 1'b0;
        chk("rst_flush_valid", out_valid, 0);
        chk("rst_flush_cnt", grant_cnt, 0);
        step(1, 8'h03, 1, 1);
        chk("post_rst_rr_y", y, 1);
        step(0, '0, 1, 1);

        // Grant counter: 5 real grants, 2 none results.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, (i == 2 || i == 5) ? 8'h00 : 8'h24, i[0], 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        chk("grant_cnt_7", grant_cnt, exp_cnt(5));

        // Random traffic with back-pressure, mode flips and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            rst = ($urandom_range(0, 60) == 0);
            step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
            rst = 1'b0;
        end
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 8, giving the request vector width (N >= 2).
REQ-002 SHALL have parameter W, default $clog2(N), giving the index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port d, input, N bits: request vector.
REQ-006 SHALL have port in_valid, input, 1 bit: d is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts d this cycle.
REQ-008 SHALL have port mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-009 SHALL have port y, output, W bits: encoded winner index.
REQ-010 SHALL have port none, output, 1 bit: the accepted d was all-zero.
REQ-011 SHALL have port out_valid, output, 1 bit: y and none are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port grant_cnt, output, 16 bits: count of delivered non-none results.

Function
REQ-014 SHALL compute in_ready = !out_valid || out_ready; accept = in_valid && in_ready.
REQ-015 SHALL register y, none and out_valid on accept, giving a latency of exactly 1 cycle from accept to out_valid.
REQ-016 In fixed mode (mode=0), y SHALL be the highest set index of d; index N-1 has top priority.
REQ-017 In round-robin mode (mode=1), the search SHALL start at index (last-1) mod N and run downward with wrap-around; the first set bit wins.
REQ-018 SHALL hold last (W bits) as the most recently granted index and update it on accept only when d!=0, in both modes.
REQ-019 When d==0 on accept, the block SHALL output y=0 and none=1, and last SHALL stay unchanged.
REQ-020 While out_valid=1 and out_ready=0, the block SHALL hold y, none and out_valid stable and accept no input.
REQ-021 On an output handshake with no accept in the same cycle, out_valid SHALL go to 0 next cycle.
REQ-022 On an output handshake and an accept in the same cycle, the new result SHALL replace the old one and out_valid SHALL stay 1.
REQ-023 A change on mode SHALL take effect on the next accept; last SHALL be preserved across mode changes.
REQ-024 d SHALL be sampled only on accept; changes on d at any other time SHALL have no effect.

Reset
REQ-025 On rst=1, the block SHALL set out_valid=0, y=0, none=0, last=0 and grant_cnt=0 at the next clock edge.
REQ-026 Reset SHALL take priority over accept and handshake; an in-flight result SHALL be discarded.
REQ-027 After reset, the first round-robin search SHALL start at index N-1, giving the same result as fixed mode.

Configuration
REQ-028 Macro PRIO_ENC_COUNT_EN SHALL control the grant counter.
REQ-029 With PRIO_ENC_COUNT_EN defined, grant_cnt SHALL increment on each output handshake with none=0 and saturate at 16'hFFFF.
REQ-030 Without PRIO_ENC_COUNT_EN, grant_cnt SHALL be tied to 0 and no counter register SHALL be built.

Structure
REQ-031 Package prio_enc_pkg SHALL hold the constants MODE_FIXED=1'b0 and MODE_RR=1'b1, the default N=8, and the counter width of 16.
REQ-032 Sub-module prio_enc_core SHALL be purely combinational: it takes d and a start index, performs the wrap-around downward search, and returns the index and a none flag.
REQ-033 The top level SHALL contain the handshake, the output register, last and the counter.

Verification (N=8)
REQ-034 After reset, with mode=0, out_ready=1, accepting d=8'b1010_0000 SHALL give, next cycle, out_valid=1, y=7, none=0.
REQ-035 Accepting d=8'h00 SHALL give y=0, none=1, and last SHALL stay unchanged.
REQ-036 With mode=1, accepting d=8'hFF four times SHALL give y=7,6,5,4; then d=8'h81 SHALL give y=0, and d=8'h81 again SHALL give y=7 (wrap).
REQ-037 With result y=3 held and out_ready=0 for 3 cycles while in_valid=1 and d=8'h10, y=3, in_ready=0 and last SHALL stay unchanged; on out_ready=1, the next result SHALL be y=4 in the following cycle.
REQ-038 Asserting rst while out_valid=1 in mode=1 SHALL make the next cycle give out_valid=0 and grant_cnt=0, and the next accept of d=8'h03 SHALL give y=1.
REQ-039 With PRIO_ENC_COUNT_EN defined, 5 non-none handshakes plus 2 none handshakes SHALL give grant_cnt=5; without the macro, grant_cnt SHALL be 0.
